openofdm_rx_pkt_supervisor: RTL and testbench
=============================================

Name: openofdm_rx_pkt_supervisor

Overview:
- Sequences and polices one receive attempt of the OFDM receiver core: tracks preamble → SIGNAL → payload → FCS progress and issues a timed receiver reset when a stage stalls or overruns.
- Keeps saturating packet/abort statistics for software.
- Sits beside the receiver core and the signal watchdog in the openofdm_rx top. Its receiver_rst is ORed into the core reset; thresholds come from AXI-lite config registers.

Parameters:
- CNT_WIDTH, 16, width of each statistics counter.
- TMO_WIDTH, 16, width of the sample-strobe timeout counters and their thresholds.
- SYM_MARGIN, 2, extra OFDM symbols tolerated beyond n_ofdm_sym before abort.

Ports:
- s00_axi_aclk  in  1  clock.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- enable  in  1  supervisor enable; low forces IDLE with no reset issued.
- sample_in_strobe  in  1  one pulse per input IQ sample (timebase).
- short_preamble_detected  in  1  short-preamble detect pulse.
- long_preamble_detected  in  1  long-preamble detect pulse.
- pkt_header_valid_strobe  in  1  SIGNAL decode done pulse.
- pkt_header_valid  in  1  SIGNAL decode result, qualified by the strobe.
- ht_unsupport  in  1  HT mode not supported, qualified by the header strobe.
- n_ofdm_sym  in  15  payload symbol count.
- phy_len_valid  in  1  pulse; n_ofdm_sym is valid in this cycle.
- ofdm_symbol_eq_out_pulse  in  1  one pulse per equalized OFDM symbol.
- fcs_out_strobe  in  1  packet end pulse.
- fcs_ok  in  1  FCS result, qualified by fcs_out_strobe.
- long_tmo_th  in  TMO_WIDTH  samples allowed from short preamble to long preamble.
- sig_tmo_th  in  TMO_WIDTH  samples allowed from long preamble to header strobe.
- rst_hold_th  in  4  receiver_rst width minus 1, in clocks.
- cnt_clear  in  1  synchronous clear of all statistics counters.
- receiver_rst  out  1  reset request to the receiver core.
- busy  out  1  high in any state other than IDLE.
- abort_strobe  out  1  one-cycle pulse on abort.
- abort_cause  out  3  cause of the last abort; held until the next abort.
- pkt_ok_cnt  out  CNT_WIDTH  count of FCS-ok packets.
- pkt_fail_cnt  out  CNT_WIDTH  count of FCS-fail packets.
- abort_cnt  out  CNT_WIDTH  count of aborts.

Behaviour:
- Reset values: all outputs 0; state IDLE; all internal counters 0.
- FSM states: IDLE, WAIT_LONG, WAIT_SIG, WAIT_PAYLOAD, RST_HOLD. All outputs are registered.
- IDLE → WAIT_LONG on short_preamble_detected while enable=1. The timeout counter tmo is cleared on entry.
- WAIT_LONG:
  - tmo increments on each sample_in_strobe.
  - long_preamble_detected → WAIT_SIG, with tmo cleared.
  - Otherwise, tmo == long_tmo_th on a strobe → abort, cause 1.
  - Repeated short_preamble_detected pulses are ignored and do not restart tmo.
- WAIT_SIG:
  - tmo increments on each sample_in_strobe.
  - Header strobe with pkt_header_valid=1 and ht_unsupport=0 → WAIT_PAYLOAD.
  - Header strobe with pkt_header_valid=0 → abort, cause 3.
  - Header strobe with ht_unsupport=1 → abort, cause 5.
  - Otherwise, tmo == sig_tmo_th on a strobe → abort, cause 2.
- WAIT_PAYLOAD:
  - sym_cnt (15b, saturating) is cleared on entry and increments on each ofdm_symbol_eq_out_pulse.
  - phy_len_valid, in any state, latches n_ofdm_sym into budget. Budget resets to 15'h7FFF on entry to IDLE.
  - sym_cnt > budget + SYM_MARGIN → abort, cause 4. This compare uses 16-bit arithmetic, so no wrap.
  - fcs_out_strobe → IDLE. pkt_ok_cnt increments if fcs_ok=1; pkt_fail_cnt increments if fcs_ok=0.
- Abort, in any waiting state:
  - Next cycle: abort_strobe=1, abort_cause latched, abort_cnt increments.
  - Go to RST_HOLD; receiver_rst=1 for exactly rst_hold_th+1 clocks, then IDLE.
  - Inputs are ignored in RST_HOLD.
- Latency: receiver_rst and abort_strobe rise one clock after the triggering input cycle.
- Simultaneous events in the same cycle:
  - The stage-completion event wins over a timeout (e.g. long preamble on the timeout strobe → WAIT_SIG).
  - fcs_out_strobe wins over the symbol-overrun abort.
  - cnt_clear wins over an increment.
- enable=0: next state is IDLE from any state except RST_HOLD, which completes its hold. No abort and no counter update.
- Counters saturate at all-ones and never wrap.
- Threshold value 0: timeout fires on the first sample strobe after the stage is entered.
- Asynchronous reset mid-operation: immediate return to reset values, including deasserting receiver_rst.

Decomposition:
- Shared package (common_params) holds:
  - the state encodings SUP_IDLE..SUP_RST_HOLD;
  - the abort cause constants: CAUSE_NONE=0, LONG_TMO=1, SIG_TMO=2, SIG_BAD=3, SYM_OVR=4, HT_UNSUP=5.
- One sub-module, sat_counter (parameterized width, inc, clr), is instantiated three times for the statistics counters.

Test Plan:
- Normal packet:
  - Stimulus: short preamble; long after 100 strobes (long_tmo_th=200); valid header; phy_len_valid with n_ofdm_sym=10; 10 symbol pulses; fcs_ok=1.
  - Required: pkt_ok_cnt=1, no abort, busy low after the FCS strobe.
- Long-preamble timeout:
  - Stimulus: long_tmo_th=50, no long preamble.
  - Required: abort_strobe one clock after the 50th strobe, cause 1, receiver_rst high for rst_hold_th+1=4 clocks (rst_hold_th=3), abort_cnt=1.
- Bad SIGNAL:
  - Stimulus: header strobe with pkt_header_valid=0.
  - Required: cause 3 and a reset pulse.
  - Repeat with ht_unsupport=1: required cause 5.
- Symbol overrun:
  - Stimulus: n_ofdm_sym=5, 8 symbol pulses, no FCS.
  - Required: abort on the 8th pulse, cause 4.
  - Repeat with fcs_out_strobe coincident with the 8th pulse: required no abort, pkt counter increments.
- Simultaneity and clear:
  - Stimulus: long preamble on the exact timeout strobe.
  - Required: WAIT_SIG, no abort.
  - Stimulus: cnt_clear coincident with FCS strobe.
  - Required: counters read 0.
- Enable and reset:
  - Stimulus: enable dropped in WAIT_PAYLOAD.
  - Required: IDLE next clock, no receiver_rst.
  - Stimulus: async reset asserted during RST_HOLD.
  - Required: receiver_rst=0 immediately.
  - Stimulus: counters preloaded near max.
  - Required: they saturate at 16'hFFFF.

Source files
------------

// File: rtl/openofdm_rx_pkt_supervisor_pkg.sv
// Shared types and helpers for the OFDM receive-attempt supervisor.
package openofdm_rx_pkt_supervisor_pkg;

  typedef enum logic [2:0] {
    SUP_IDLE,
    SUP_WAIT_LONG,
    SUP_WAIT_SIG,
    SUP_WAIT_PAYLOAD,
    SUP_RST_HOLD
  } sup_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_LONG_TMO = 3'd1,
    CAUSE_SIG_TMO  = 3'd2,
    CAUSE_SIG_BAD  = 3'd3,
    CAUSE_SYM_OVR  = 3'd4,
    CAUSE_HT_UNSUP = 3'd5
  } abort_cause_t;

  localparam logic [14:0] BUDGET_INIT = 15'h7FFF;

  // One extra bit so budget + margin cannot wrap past a saturated symbol count.
  function automatic logic sym_overrun(input logic [14:0] sym,
                                       input logic [14:0] budget,
                                       input int unsigned margin);
    return {1'b0, sym} > ({1'b0, budget} + 16'(margin));
  endfunction

endpackage

// File: rtl/openofdm_rx_pkt_supervisor_sat_counter.sv
// Saturating statistics counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/openofdm_rx_pkt_supervisor.sv
// Receive-attempt supervisor: tracks preamble/SIGNAL/payload/FCS progress, aborts
// stalled or overrunning attempts with a timed receiver reset, and keeps packet statistics.
module openofdm_rx_pkt_supervisor
  import openofdm_rx_pkt_supervisor_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int TMO_WIDTH  = 16,
  parameter int SYM_MARGIN = 2
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  input  logic                 enable,
  input  logic                 sample_in_strobe,
  input  logic                 short_preamble_detected,
  input  logic                 long_preamble_detected,
  input  logic                 pkt_header_valid_strobe,
  input  logic                 pkt_header_valid,
  input  logic                 ht_unsupport,
  input  logic [14:0]          n_ofdm_sym,
  input  logic                 phy_len_valid,
  input  logic                 ofdm_symbol_eq_out_pulse,
  input  logic                 fcs_out_strobe,
  input  logic                 fcs_ok,
  input  logic [TMO_WIDTH-1:0] long_tmo_th,
  input  logic [TMO_WIDTH-1:0] sig_tmo_th,
  input  logic [3:0]           rst_hold_th,
  input  logic                 cnt_clear,
  output logic                 receiver_rst,
  output logic                 busy,
  output logic                 abort_strobe,
  output logic [2:0]           abort_cause,
  output logic [CNT_WIDTH-1:0] pkt_ok_cnt,
  output logic [CNT_WIDTH-1:0] pkt_fail_cnt,
  output logic [CNT_WIDTH-1:0] abort_cnt
);

  sup_state_t           r_state;
  logic [TMO_WIDTH-1:0] r_tmo;
  logic [14:0]          r_sym_cnt;
  logic [14:0]          r_budget;
  logic [3:0]           r_hold_cnt;
  logic                 r_receiver_rst;
  logic                 r_busy;
  logic                 r_abort_strobe;
  abort_cause_t         r_abort_cause;

  logic [TMO_WIDTH:0]   w_tmo_inc;
  logic [14:0]          w_sym_next;
  logic                 w_abort;
  abort_cause_t         w_cause;
  logic                 w_fcs_done;

  assign w_tmo_inc  = {1'b0, r_tmo} + (TMO_WIDTH + 1)'(1);
  assign w_sym_next = (ofdm_symbol_eq_out_pulse && (r_sym_cnt != '1)) ? r_sym_cnt + 15'd1
                                                                       : r_sym_cnt;

  // Timeout fires when this strobe brings the stage's strobe count to the threshold;
  // a threshold of 0 therefore fires on the very first strobe.
  always_comb begin
    w_abort    = 1'b0;
    w_cause    = CAUSE_NONE;
    w_fcs_done = 1'b0;
    if (enable) begin
      case (r_state)
        SUP_WAIT_LONG: begin
          if (!long_preamble_detected && sample_in_strobe &&
              (w_tmo_inc >= {1'b0, long_tmo_th})) begin
            w_abort = 1'b1;
            w_cause = CAUSE_LONG_TMO;
          end
        end
        SUP_WAIT_SIG: begin
          if (pkt_header_valid_strobe) begin
            if (!pkt_header_valid) begin
              w_abort = 1'b1;
              w_cause = CAUSE_SIG_BAD;
            end else if (ht_unsupport) begin
              w_abort = 1'b1;
              w_cause = CAUSE_HT_UNSUP;
            end
          end else if (sample_in_strobe && (w_tmo_inc >= {1'b0, sig_tmo_th})) begin
            w_abort = 1'b1;
            w_cause = CAUSE_SIG_TMO;
          end
        end
        SUP_WAIT_PAYLOAD: begin
          if (fcs_out_strobe) begin
            w_fcs_done = 1'b1;
          end else if (sym_overrun(w_sym_next, r_budget, SYM_MARGIN)) begin
            w_abort = 1'b1;
            w_cause = CAUSE_SYM_OVR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state        <= SUP_IDLE;
      r_tmo          <= '0;
      r_sym_cnt      <= '0;
      r_budget       <= BUDGET_INIT;
      r_hold_cnt     <= '0;
      r_receiver_rst <= 1'b0;
      r_busy         <= 1'b0;
      r_abort_strobe <= 1'b0;
      r_abort_cause  <= CAUSE_NONE;
    end else begin
      r_abort_strobe <= w_abort;
      if (w_abort) r_abort_cause <= w_cause;
      if (phy_len_valid) r_budget <= n_ofdm_sym;

      if (w_abort) begin
        r_state        <= SUP_RST_HOLD;
        r_receiver_rst <= 1'b1;
        r_busy         <= 1'b1;
        r_hold_cnt     <= '0;
      end else if (!enable && (r_state != SUP_RST_HOLD)) begin
        r_state <= SUP_IDLE;
        r_busy  <= 1'b0;
        if (r_state != SUP_IDLE) r_budget <= BUDGET_INIT;
      end else begin
        case (r_state)
          SUP_IDLE: begin
            if (short_preamble_detected) begin
              r_state <= SUP_WAIT_LONG;
              r_busy  <= 1'b1;
              r_tmo   <= '0;
            end
          end
          SUP_WAIT_LONG: begin
            if (long_preamble_detected) begin
              r_state <= SUP_WAIT_SIG;
              r_tmo   <= '0;
            end else if (sample_in_strobe) begin
              r_tmo <= w_tmo_inc[TMO_WIDTH-1:0];
            end
          end
          SUP_WAIT_SIG: begin
            // A header strobe reaching here was good; bad ones took the abort branch.
            if (pkt_header_valid_strobe) begin
              r_state   <= SUP_WAIT_PAYLOAD;
              r_sym_cnt <= '0;
            end else if (sample_in_strobe) begin
              r_tmo <= w_tmo_inc[TMO_WIDTH-1:0];
            end
          end
          SUP_WAIT_PAYLOAD: begin
            if (fcs_out_strobe) begin
              r_state  <= SUP_IDLE;
              r_busy   <= 1'b0;
              r_budget <= BUDGET_INIT;
            end else begin
              r_sym_cnt <= w_sym_next;
            end
          end
          SUP_RST_HOLD: begin
            if (r_hold_cnt == rst_hold_th) begin
              r_state        <= SUP_IDLE;
              r_receiver_rst <= 1'b0;
              r_busy         <= 1'b0;
              r_budget       <= BUDGET_INIT;
            end else begin
              r_hold_cnt <= r_hold_cnt + 4'd1;
            end
          end
          default: begin
            r_state <= SUP_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_ok_cnt (
    .i_clk   (s00_axi_aclk),
    .i_rst_n (s00_axi_aresetn),
    .i_clr   (cnt_clear),
    .i_inc   (w_fcs_done && fcs_ok),
    .o_cnt   (pkt_ok_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_fail_cnt (
    .i_clk   (s00_axi_aclk),
    .i_rst_n (s00_axi_aresetn),
    .i_clr   (cnt_clear),
    .i_inc   (w_fcs_done && !fcs_ok),
    .o_cnt   (pkt_fail_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_abort_cnt (
    .i_clk   (s00_axi_aclk),
    .i_rst_n (s00_axi_aresetn),
    .i_clr   (cnt_clear),
    .i_inc   (w_abort),
    .o_cnt   (abort_cnt)
  );

  assign receiver_rst = r_receiver_rst;
  assign busy         = r_busy;
  assign abort_strobe = r_abort_strobe;
  assign abort_cause  = r_abort_cause;

endmodule

// File: tb/tb_openofdm_rx_pkt_supervisor.sv
// Bench for the receive-attempt supervisor: vector table, directed corner cases and
// random traffic against a behavioural model; a 3-bit-counter twin exercises saturation.
module tb_openofdm_rx_pkt_supervisor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, strb, sp, lp, hs, hv, ht, plv, symp, fcs, fok, clr;
  logic [14:0] nsym;
  logic [15:0] lth, sth;
  logic [3:0]  hth;

  logic        rrst, busy, astb;
  logic [2:0]  cause;
  logic [15:0] okc, failc, abc;
  logic        rrst2, busy2, astb2;
  logic [2:0]  cause2;
  logic [2:0]  okc2, failc2, abc2;

  openofdm_rx_pkt_supervisor #(.CNT_WIDTH(16), .TMO_WIDTH(16), .SYM_MARGIN(2)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .enable(en),
    .sample_in_strobe(strb), .short_preamble_detected(sp), .long_preamble_detected(lp),
    .pkt_header_valid_strobe(hs), .pkt_header_valid(hv), .ht_unsupport(ht),
    .n_ofdm_sym(nsym), .phy_len_valid(plv), .ofdm_symbol_eq_out_pulse(symp),
    .fcs_out_strobe(fcs), .fcs_ok(fok), .long_tmo_th(lth), .sig_tmo_th(sth),
    .rst_hold_th(hth), .cnt_clear(clr), .receiver_rst(rrst), .busy(busy),
    .abort_strobe(astb), .abort_cause(cause), .pkt_ok_cnt(okc),
    .pkt_fail_cnt(failc), .abort_cnt(abc)
  );

  openofdm_rx_pkt_supervisor #(.CNT_WIDTH(3), .TMO_WIDTH(16), .SYM_MARGIN(2)) dut_sat (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .enable(en),
    .sample_in_strobe(strb), .short_preamble_detected(sp), .long_preamble_detected(lp),
    .pkt_header_valid_strobe(hs), .pkt_header_valid(hv), .ht_unsupport(ht),
    .n_ofdm_sym(nsym), .phy_len_valid(plv), .ofdm_symbol_eq_out_pulse(symp),
    .fcs_out_strobe(fcs), .fcs_ok(fok), .long_tmo_th(lth), .sig_tmo_th(sth),
    .rst_hold_th(hth), .cnt_clear(clr), .receiver_rst(rrst2), .busy(busy2),
    .abort_strobe(astb2), .abort_cause(cause2), .pkt_ok_cnt(okc2),
    .pkt_fail_cnt(failc2), .abort_cnt(abc2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_eq(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Behavioural model: attempt phase, strobes seen in the current stage, symbols seen,
  // remaining reset-hold clocks, and unbounded event tallies.
  localparam int P_IDLE = 0, P_LONG = 1, P_SIG = 2, P_PAY = 3, P_HOLD = 4;
  int m_phase, m_strobes, m_sym, m_budget, m_left;
  int m_rst, m_busy, m_astb, m_cause, m_ok, m_fail, m_ab;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_strobes = 0; m_sym = 0; m_budget = 32767; m_left = 0;
    m_rst = 0; m_busy = 0; m_astb = 0; m_cause = 0; m_ok = 0; m_fail = 0; m_ab = 0;
  endtask

  task automatic model_step();
    int ab, c, done, old_budget;
    ab = 0; c = 0; done = 0;
    old_budget = m_budget;
    m_astb = 0;
    if (plv) m_budget = int'(nsym);
    if (m_phase == P_HOLD) begin
      m_left--;
      if (m_left == 0) begin m_phase = P_IDLE; m_budget = 32767; end
    end else if (!en) begin
      if (m_phase != P_IDLE) m_budget = 32767;
      m_phase = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE: if (sp) begin m_phase = P_LONG; m_strobes = 0; end
        P_LONG: begin
          if (lp) begin m_phase = P_SIG; m_strobes = 0; end
          else if (strb) begin
            m_strobes++;
            if (m_strobes >= int'(lth)) begin ab = 1; c = 1; end
          end
        end
        P_SIG: begin
          if (hs) begin
            if (!hv) begin ab = 1; c = 3; end
            else if (ht) begin ab = 1; c = 5; end
            else begin m_phase = P_PAY; m_sym = 0; end
          end else if (strb) begin
            m_strobes++;
            if (m_strobes >= int'(sth)) begin ab = 1; c = 2; end
          end
        end
        P_PAY: begin
          if (fcs) begin done = 1; m_phase = P_IDLE; m_budget = 32767; end
          else begin
            m_sym = sat(m_sym + int'(symp), 32767);
            if (m_sym > old_budget + 2) begin ab = 1; c = 4; end
          end
        end
        default: ;
      endcase
    end
    if (ab) begin m_phase = P_HOLD; m_left = int'(hth) + 1; m_astb = 1; m_cause = c; end
    if (clr) begin m_ok = 0; m_fail = 0; m_ab = 0; end
    else begin
      if (done && fok)  m_ok++;
      if (done && !fok) m_fail++;
      if (ab)           m_ab++;
    end
    m_rst  = (m_phase == P_HOLD) ? 1 : 0;
    m_busy = (m_phase != P_IDLE) ? 1 : 0;
  endtask

  task automatic check_all();
    expect_eq("rst",   int'(rrst),  m_rst);
    expect_eq("busy",  int'(busy),  m_busy);
    expect_eq("astb",  int'(astb),  m_astb);
    expect_eq("cause", int'(cause), m_cause);
    expect_eq("okc",   int'(okc),   sat(m_ok, 65535));
    expect_eq("failc", int'(failc), sat(m_fail, 65535));
    expect_eq("abc",   int'(abc),   sat(m_ab, 65535));
    expect_eq("sat_rst",   int'(rrst2),  m_rst);
    expect_eq("sat_busy",  int'(busy2),  m_busy);
    expect_eq("sat_okc",   int'(okc2),   sat(m_ok, 7));
    expect_eq("sat_failc", int'(failc2), sat(m_fail, 7));
    expect_eq("sat_abc",   int'(abc2),   sat(m_ab, 7));
  endtask

  // One clock: inputs already set, model advanced at the edge, outputs checked 1ns later,
  // then all single-cycle pulses dropped.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    sp = 0; lp = 0; hs = 0; plv = 0; symp = 0; fcs = 0; clr = 0; strb = 0;
  endtask

  task automatic to_payload();
    sp = 1; tick();
    lp = 1; tick();
    hs = 1; hv = 1; ht = 0; tick();
  endtask

  typedef struct {
    logic sp, lp, hs, hv, ht, fcs;
    int   e_rst, e_busy, e_astb, e_cause;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, n;
    rst_n = 0; en = 1; strb = 0; sp = 0; lp = 0; hs = 0; hv = 0; ht = 0; plv = 0;
    symp = 0; fcs = 0; fok = 0; clr = 0; nsym = '0;
    lth = 16'd1000; sth = 16'd1000; hth = 4'd1;
    model_reset();

    #1;
    expect_eq("reset_rst",   int'(rrst),  0);
    expect_eq("reset_busy",  int'(busy),  0);
    expect_eq("reset_astb",  int'(astb),  0);
    expect_eq("reset_cause", int'(cause), 0);
    expect_eq("reset_okc",   int'(okc),   0);
    expect_eq("reset_abc",   int'(abc),   0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    //          sp lp hs hv ht fcs  rst busy astb cause
    tbl[0]  = '{1, 0, 0, 0, 0, 0,   0, 1, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0,   0, 1, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 0, 0,   1, 1, 1, 3};
    tbl[3]  = '{0, 0, 0, 0, 0, 0,   1, 1, 0, 3};
    tbl[4]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 3};
    tbl[5]  = '{1, 0, 0, 0, 0, 0,   0, 1, 0, 3};
    tbl[6]  = '{0, 1, 0, 0, 0, 0,   0, 1, 0, 3};
    tbl[7]  = '{0, 0, 1, 1, 1, 0,   1, 1, 1, 5};
    tbl[8]  = '{1, 0, 0, 0, 0, 0,   1, 1, 0, 5};
    tbl[9]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 5};
    tbl[10] = '{1, 0, 0, 0, 0, 0,   0, 1, 0, 5};
    tbl[11] = '{0, 1, 0, 0, 0, 0,   0, 1, 0, 5};
    tbl[12] = '{0, 0, 1, 1, 0, 0,   0, 1, 0, 5};
    tbl[13] = '{0, 0, 0, 1, 0, 1,   0, 0, 0, 5};
    fok = 1;
    for (int i = 0; i < 14; i++) begin
      sp = tbl[i].sp; lp = tbl[i].lp; hs = tbl[i].hs; hv = tbl[i].hv; ht = tbl[i].ht;
      fcs = tbl[i].fcs;
      tick();
      expect_eq($sformatf("vec%0d_rst", i),   int'(rrst),  tbl[i].e_rst);
      expect_eq($sformatf("vec%0d_busy", i),  int'(busy),  tbl[i].e_busy);
      expect_eq($sformatf("vec%0d_astb", i),  int'(astb),  tbl[i].e_astb);
      expect_eq($sformatf("vec%0d_cause", i), int'(cause), tbl[i].e_cause);
    end
    expect_eq("vec_okc", int'(okc), 1);
    expect_eq("vec_abc", int'(abc), 2);

    // Normal packet
    lth = 16'd200; sth = 16'd200; hth = 4'd3;
    sp = 1; tick();
    for (int i = 0; i < 100; i++) begin strb = 1; tick(); end
    lp = 1; tick();
    hs = 1; hv = 1; ht = 0; tick();
    plv = 1; nsym = 15'd10; tick();
    for (int i = 0; i < 10; i++) begin symp = 1; tick(); end
    fcs = 1; fok = 1; tick();
    expect_eq("normal_okc",  int'(okc),  2);
    expect_eq("normal_abc",  int'(abc),  2);
    expect_eq("normal_busy", int'(busy), 0);

    // Long-preamble timeout: abort flagged right after the 50th strobe, 4-clock reset
    lth = 16'd50;
    sp = 1; tick();
    k = -1;
    for (int i = 1; i <= 200; i++) begin
      strb = 1; tick();
      if (astb) begin k = i; break; end
    end
    expect_eq("ltmo_strobe_idx", k, 50);
    expect_eq("ltmo_cause", int'(cause), 1);
    expect_eq("ltmo_abc", int'(abc), 3);
    n = 0;
    for (int i = 0; i < 20 && rrst; i++) begin n++; tick(); end
    expect_eq("ltmo_rst_width", n, 4);

    // Symbol overrun on the 8th pulse with n_ofdm_sym=5
    to_payload();
    plv = 1; nsym = 15'd5; tick();
    k = -1;
    for (int i = 1; i <= 8; i++) begin
      symp = 1; tick();
      if (astb && k < 0) k = i;
    end
    expect_eq("ovr_pulse_idx", k, 8);
    expect_eq("ovr_cause", int'(cause), 4);
    repeat (6) tick();
    // Same, but FCS arrives with the 8th pulse
    to_payload();
    plv = 1; nsym = 15'd5; tick();
    for (int i = 1; i <= 7; i++) begin symp = 1; tick(); end
    symp = 1; fcs = 1; fok = 1; tick();
    expect_eq("ovr_fcs_astb", int'(astb), 0);
    expect_eq("ovr_fcs_busy", int'(busy), 0);
    expect_eq("ovr_fcs_okc",  int'(okc),  3);

    // Long preamble on the exact timeout strobe, then SIG threshold 0
    lth = 16'd10; sth = 16'd0;
    sp = 1; tick();
    for (int i = 0; i < 9; i++) begin strb = 1; tick(); end
    strb = 1; lp = 1; tick();
    expect_eq("simul_astb", int'(astb), 0);
    expect_eq("simul_busy", int'(busy), 1);
    strb = 1; tick();
    expect_eq("sig0_astb",  int'(astb),  1);
    expect_eq("sig0_cause", int'(cause), 2);
    repeat (6) tick();

    // Clear coincident with FCS strobe
    to_payload();
    fcs = 1; fok = 0; clr = 1; tick();
    expect_eq("clr_okc",   int'(okc),   0);
    expect_eq("clr_failc", int'(failc), 0);
    expect_eq("clr_abc",   int'(abc),   0);

    // Enable dropped in payload
    to_payload();
    en = 0; tick();
    expect_eq("en_busy", int'(busy), 0);
    expect_eq("en_rst",  int'(rrst), 0);
    en = 1; tick();

    // Async reset during reset hold
    lth = 16'd0; hth = 4'd5;
    sp = 1; tick();
    strb = 1; tick();
    tick();
    expect_eq("ar_rst_before", int'(rrst), 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    expect_eq("ar_rst",  int'(rrst),  0);
    expect_eq("ar_busy", int'(busy),  0);
    expect_eq("ar_astb", int'(astb),  0);
    expect_eq("ar_cause", int'(cause), 0);
    #2 rst_n = 1;

    // Random traffic
    for (int seg = 0; seg < 6; seg++) begin
      en = 0;
      repeat (6) tick();
      lth = 16'($urandom_range(0, 20));
      sth = 16'($urandom_range(0, 20));
      hth = 4'($urandom_range(0, 4));
      for (int i = 0; i < 400; i++) begin
        en   = ($urandom % 60) != 0;
        sp   = ($urandom % 8) == 0;
        lp   = ($urandom % 10) == 0;
        hs   = ($urandom % 12) == 0;
        hv   = ($urandom % 4) != 0;
        ht   = ($urandom % 6) == 0;
        strb = ($urandom % 2) == 0;
        plv  = ($urandom % 15) == 0;
        nsym = 15'($urandom_range(0, 12));
        symp = ($urandom % 3) == 0;
        fcs  = ($urandom % 20) == 0;
        fok  = ($urandom % 2) == 0;
        clr  = ($urandom % 150) == 0;
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
